// File: rtl/sw_test_status_pkg.sv
// Shared types and constants for the software test-status controller:
// FSM state encoding, recognised status codes and the default status address.
package sw_test_status_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StBootRom = 3'd1,
        StInTest  = 3'd2,
        StPassed  = 3'd3,
        StFailed  = 3'd4,
        StTimeout = 3'd5
    } test_state_e;

    localparam logic [15:0] CodeBootRom = 16'hB004;
    localparam logic [15:0] CodeInTest  = 16'h4354;
    localparam logic [15:0] CodePassed  = 16'h900D;
    localparam logic [15:0] CodeFailed  = 16'hBAAD;

    localparam logic [31:0] DefaultStatusAddr = 32'h411F_0080;

    // Terminal states are sticky until reset.
    function automatic logic is_terminal(input test_state_e s);
        return (s == StPassed) || (s == StFailed) || (s == StTimeout);
    endfunction

    function automatic logic is_code(input logic [15:0] d);
        return (d == CodeBootRom) || (d == CodeInTest) ||
               (d == CodePassed)  || (d == CodeFailed);
    endfunction

endpackage

// File: rtl/sw_test_status_rr_arb.sv
// Combinational round-robin arbiter: the first requester at or after ptr_i
// (wrapping modulo NumReq) wins; grant is one-hot with its binary index.
module sw_test_status_rr_arb #(
    parameter int NumReq = 4
) (
    input  logic [NumReq-1:0]         req_i,
    input  logic [$clog2(NumReq)-1:0] ptr_i,
    output logic [NumReq-1:0]         gnt_o,
    output logic [$clog2(NumReq)-1:0] idx_o,
    output logic                      valid_o
);

    localparam int IdxW = $clog2(NumReq);

    logic [IdxW:0] cand;

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        cand    = '0;
        for (int i = 0; i < NumReq; i++) begin
            // One extra bit so ptr + offset cannot overflow before the wrap.
            cand = {1'b0, ptr_i} + (IdxW + 1)'(i);
            if (cand >= (IdxW + 1)'(NumReq)) begin
                cand = cand - (IdxW + 1)'(NumReq);
            end
            if (!valid_o && req_i[cand[IdxW-1:0]]) begin
                valid_o                = 1'b1;
                gnt_o[cand[IdxW-1:0]]  = 1'b1;
                idx_o                  = cand[IdxW-1:0];
            end
        end
    end

endmodule

// File: rtl/sw_test_status_ctrl.sv
// Arbitrates requester writes onto a single registered write port and tracks
// software test progress from status codes written to StatusAddr, with a watchdog.
module sw_test_status_ctrl
    import sw_test_status_pkg::*;
#(
    parameter int                   NumReq        = 4,
    parameter int                   AddrWidth     = 32,
    parameter logic [AddrWidth-1:0] StatusAddr    = AddrWidth'(DefaultStatusAddr),
    parameter int                   TimeoutCycles = 1_000_000
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic [NumReq-1:0]           req_valid_i,
    input  logic [NumReq*AddrWidth-1:0] req_addr_i,
    input  logic [NumReq*16-1:0]        req_data_i,
    output logic [NumReq-1:0]           req_ready_o,
    output logic                        wr_valid_o,
    output logic [AddrWidth-1:0]        wr_addr_o,
    output logic [15:0]                 wr_data_o,
    output logic [2:0]                  test_state_o,
    output logic                        test_done_o,
    output logic                        test_passed_o
);

    localparam int IdxW = $clog2(NumReq);
    localparam int CntW = $clog2(TimeoutCycles + 1);

    // Handshake: requester i's write is taken on a rising clk_i edge where
    // req_valid_i[i] && req_ready_o[i]; ready is one-hot and only on a valid line.
    logic [NumReq-1:0]    gnt;
    logic [IdxW-1:0]      gnt_idx;
    logic                 gnt_any;
    logic [AddrWidth-1:0] sel_addr;
    logic [15:0]          sel_data;

    logic [IdxW-1:0]      rr_q, rr_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [AddrWidth-1:0] wr_addr_q, wr_addr_d;
    logic [15:0]          wr_data_q, wr_data_d;
    test_state_e          state_q, state_d;
    logic [CntW-1:0]      cnt_q, cnt_d;
    logic                 done_q, done_d;
    logic                 passed_q, passed_d;
    logic                 code_hit;

    sw_test_status_rr_arb #(
        .NumReq (NumReq)
    ) u_arb (
        .req_i   (req_valid_i),
        .ptr_i   (rr_q),
        .gnt_o   (gnt),
        .idx_o   (gnt_idx),
        .valid_o (gnt_any)
    );

    assign req_ready_o = gnt;

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int i = 0; i < NumReq; i++) begin
            if (gnt[i]) begin
                sel_addr = req_addr_i[i*AddrWidth +: AddrWidth];
                sel_data = req_data_i[i*16 +: 16];
            end
        end
    end

    always_comb begin
        rr_d       = rr_q;
        wr_valid_d = gnt_any;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        if (gnt_any) begin
            rr_d      = (gnt_idx == IdxW'(NumReq - 1)) ? '0 : gnt_idx + IdxW'(1);
            wr_addr_d = sel_addr;
            wr_data_d = sel_data;
        end
    end

    // Only the registered write is decoded, so state lags acceptance by two cycles.
    assign code_hit = wr_valid_q && (wr_addr_q == StatusAddr) && is_code(wr_data_q);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (!is_terminal(state_q)) begin
            if (code_hit) begin
                cnt_d = '0;
                case (wr_data_q)
                    CodeBootRom: state_d = StBootRom;
                    CodeInTest:  state_d = StInTest;
                    CodePassed:  state_d = StPassed;
                    CodeFailed:  state_d = StFailed;
                    default:     state_d = state_q;
                endcase
            end else if (state_q == StInTest) begin
                // A code landing on the final watchdog cycle wins over the timeout.
                if (cnt_q == CntW'(TimeoutCycles - 1)) begin
                    state_d = StTimeout;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
        end
        done_d   = is_terminal(state_d);
        passed_d = (state_d == StPassed);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q       <= '0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            state_q    <= StIdle;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            passed_q   <= 1'b0;
        end else begin
            rr_q       <= rr_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            done_q     <= done_d;
            passed_q   <= passed_d;
        end
    end

    assign wr_valid_o    = wr_valid_q;
    assign wr_addr_o     = wr_addr_q;
    assign wr_data_o     = wr_data_q;
    assign test_state_o  = state_q;
    assign test_done_o   = done_q;
    assign test_passed_o = passed_q;

endmodule

// File: tb/tb_sw_test_status_ctrl.sv
// Self-checking bench for sw_test_status_ctrl: reference round-robin model,
// forwarded-write scoreboard and directed status/watchdog scenarios.
module tb_sw_test_status_ctrl;

    localparam int NumReq = 4;
    localparam int AW     = 32;
    localparam int TO     = 16;
    localparam logic [31:0] SA = 32'h411F_0080;

    logic              clk_i = 1'b0;
    logic              rst_ni;
    logic [NumReq-1:0] req_valid_i;
    logic [NumReq*AW-1:0] req_addr_i;
    logic [NumReq*16-1:0] req_data_i;
    logic [NumReq-1:0] req_ready_o;
    logic              wr_valid_o;
    logic [AW-1:0]     wr_addr_o;
    logic [15:0]       wr_data_o;
    logic [2:0]        test_state_o;
    logic              test_done_o;
    logic              test_passed_o;

    logic [AW+15:0] exp_q[$];
    logic [AW+15:0] mon_e;
    int n_pass  = 0;
    int n_total = 0;
    int model_rr = 0;

    sw_test_status_ctrl #(
        .NumReq        (NumReq),
        .AddrWidth     (AW),
        .StatusAddr    (SA),
        .TimeoutCycles (TO)
    ) dut (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .req_valid_i   (req_valid_i),
        .req_addr_i    (req_addr_i),
        .req_data_i    (req_data_i),
        .req_ready_o   (req_ready_o),
        .wr_valid_o    (wr_valid_o),
        .wr_addr_o     (wr_addr_o),
        .wr_data_o     (wr_data_o),
        .test_state_o  (test_state_o),
        .test_done_o   (test_done_o),
        .test_passed_o (test_passed_o)
    );

    // clock / reset
    always #5 clk_i = ~clk_i;

    // scoreboard: every forwarded write must match the oldest accepted one
    always @(negedge clk_i) begin
        if (rst_ni && wr_valid_o) begin
            n_total++;
            if (exp_q.size() == 0) begin
                $display("FAIL wr_unexpected: got addr=%h data=%h, required no write", wr_addr_o, wr_data_o);
            end else begin
                mon_e = exp_q.pop_front();
                if ({wr_addr_o, wr_data_o} !== mon_e) begin
                    $display("FAIL wr_forward: got %h_%h, required %h_%h",
                             wr_addr_o, wr_data_o, mon_e[AW+15:16], mon_e[15:0]);
                end else begin
                    n_pass++;
                end
            end
        end
    end

    // driver tasks (called at posedge+1, return at the next posedge+1)
    task automatic set_req(input int r, input logic [31:0] a, input logic [15:0] d);
        req_addr_i[r*AW +: AW] = a;
        req_data_i[r*16 +: 16] = d;
    endtask

    task automatic step(input logic [NumReq-1:0] v);
        logic [NumReq-1:0] exp_gnt;
        int g;
        int c;
        req_valid_i = v;
        #1;
        exp_gnt = '0;
        g = -1;
        for (int k = 0; k < NumReq; k++) begin
            c = (model_rr + k) % NumReq;
            if (g < 0 && v[c]) g = c;
        end
        if (g >= 0) exp_gnt[g] = 1'b1;
        n_total++;
        if (req_ready_o !== exp_gnt) begin
            $display("FAIL grant: valid=%b got ready=%b, required %b", v, req_ready_o, exp_gnt);
        end else begin
            n_pass++;
        end
        if (g >= 0) begin
            exp_q.push_back({req_addr_i[g*AW +: AW], req_data_i[g*16 +: 16]});
            model_rr = (g + 1) % NumReq;
        end
        @(posedge clk_i);
        #1;
    endtask

    task automatic apply_reset();
        req_valid_i = '0;
        rst_ni = 1'b0;
        exp_q.delete();
        model_rr = 0;
        #1;
        n_total++;
        if ({wr_valid_o, wr_addr_o, wr_data_o, test_state_o, test_done_o, test_passed_o} !== '0) begin
            $display("FAIL reset_async: got valid=%b addr=%h data=%h state=%0d done=%b passed=%b, required all 0",
                     wr_valid_o, wr_addr_o, wr_data_o, test_state_o, test_done_o, test_passed_o);
        end else begin
            n_pass++;
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic check_state(input string name, input logic [2:0] st, input logic done, input logic passed);
        n_total++;
        if ({test_state_o, test_done_o, test_passed_o} !== {st, done, passed}) begin
            $display("FAIL %s: got state=%0d done=%b passed=%b, required state=%0d done=%b passed=%b",
                     name, test_state_o, test_done_o, test_passed_o, st, done, passed);
        end else begin
            n_pass++;
        end
    endtask

    task automatic test_reset();
        rst_ni = 1'b1;
        req_valid_i = '0;
        req_addr_i = '0;
        req_data_i = '0;
        #1;
        rst_ni = 1'b0;
        #2;
        n_total++;
        if ({wr_valid_o, wr_addr_o, wr_data_o, test_state_o, test_done_o, test_passed_o, req_ready_o} !== '0) begin
            $display("FAIL reset_state: got valid=%b addr=%h data=%h state=%0d done=%b passed=%b, required all 0",
                     wr_valid_o, wr_addr_o, wr_data_o, test_state_o, test_done_o, test_passed_o);
        end else begin
            n_pass++;
        end
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_round_robin();
        logic exp_v;
        for (int r = 0; r < NumReq; r++) set_req(r, 32'h1000_0000 + 32'(r * 4), 16'(16'hA000 + r));
        for (int i = 0; i < 6; i++) begin
            exp_v = (i >= 1 && i <= 4);
            n_total++;
            if (wr_valid_o !== exp_v) begin
                $display("FAIL rr_wr_valid: cycle %0d got %b, required %b", i + 1, wr_valid_o, exp_v);
            end else begin
                n_pass++;
            end
            step((i < 4) ? 4'b1111 : 4'b0000);
        end
    endtask

    task automatic test_boot_sequence();
        set_req(2, SA, 16'hB004);
        step(4'b0100);
        check_state("boot_lat1", 3'd0, 1'b0, 1'b0);
        set_req(2, SA, 16'h4354);
        step(4'b0100);
        check_state("boot_bootrom", 3'd1, 1'b0, 1'b0);
        step(4'b0000);
        check_state("boot_intest", 3'd2, 1'b0, 1'b0);
    endtask

    task automatic test_timeout();
        for (int i = 0; i < TO - 1; i++) step(4'b0000);
        check_state("timeout_before", 3'd2, 1'b0, 1'b0);
        step(4'b0000);
        check_state("timeout_hit", 3'd5, 1'b1, 1'b0);
    endtask

    task automatic test_code_priority();
        set_req(0, SA, 16'h4354);
        step(4'b0001);
        step(4'b0000);
        check_state("prio_intest", 3'd2, 1'b0, 1'b0);
        for (int i = 0; i < TO - 2; i++) step(4'b0000);
        set_req(1, SA, 16'h900D);
        step(4'b0010);
        check_state("prio_last_cycle", 3'd2, 1'b0, 1'b0);
        step(4'b0000);
        check_state("prio_passed", 3'd3, 1'b1, 1'b1);
        set_req(3, SA, 16'hBAAD);
        step(4'b1000);
        step(4'b0000);
        step(4'b0000);
        check_state("prio_sticky", 3'd3, 1'b1, 1'b1);
    endtask

    task automatic test_addr_filter();
        set_req(0, SA, 16'hB004);
        step(4'b0001);
        step(4'b0000);
        check_state("filter_bootrom", 3'd1, 1'b0, 1'b0);
        set_req(1, SA + 32'd4, 16'h900D);
        step(4'b0010);
        n_total++;
        if ({wr_valid_o, wr_addr_o, wr_data_o} !== {1'b1, SA + 32'd4, 16'h900D}) begin
            $display("FAIL filter_forward: got valid=%b addr=%h data=%h, required 1 %h 900d",
                     wr_valid_o, wr_addr_o, wr_data_o, SA + 32'd4);
        end else begin
            n_pass++;
        end
        step(4'b0000);
        step(4'b0000);
        check_state("filter_unchanged", 3'd1, 1'b0, 1'b0);
    endtask

    task automatic test_reset_mid_transfer();
        set_req(2, SA, 16'h4354);
        step(4'b0100);
        step(4'b0000);
        check_state("mid_intest", 3'd2, 1'b0, 1'b0);
        set_req(2, 32'h3000_0000, 16'h1234);
        step(4'b0100);
        n_total++;
        if (wr_valid_o !== 1'b1) begin
            $display("FAIL mid_pending: got wr_valid=%b, required 1", wr_valid_o);
        end else begin
            n_pass++;
        end
        apply_reset();
        for (int r = 0; r < NumReq; r++) set_req(r, 32'h3000_0100 + 32'(r * 4), 16'(16'h5000 + r));
        step(4'b1111);
        step(4'b0000);
        check_state("mid_after_reset", 3'd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 40; i++) begin
            for (int r = 0; r < NumReq; r++) begin
                set_req(r, 32'h2000_0000 + 32'($urandom_range(0, 255) * 4), 16'($urandom_range(0, 65535)));
            end
            step(4'($urandom_range(0, 15)));
        end
        step(4'b0000);
        step(4'b0000);
        check_state("b2b_state", 3'd0, 1'b0, 1'b0);
        n_total++;
        if (exp_q.size() != 0) begin
            $display("FAIL b2b_drain: got %0d writes outstanding, required 0", exp_q.size());
        end else begin
            n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_round_robin();
        test_boot_sequence();
        test_timeout();
        apply_reset();
        test_code_priority();
        apply_reset();
        test_addr_filter();
        test_reset_mid_transfer();
        apply_reset();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sw_test_status_ctrl.md
SW_TEST_STATUS_CTRL -- requirements
Module: sw_test_status_ctrl

Interface
REQ-001 SHALL have parameter NumReq, default 4: number of write requesters (2..8).
REQ-002 SHALL have parameter AddrWidth, default 32: address width.
REQ-003 SHALL have parameter StatusAddr, default 32'h411F_0080: address that carries test-status codes.
REQ-004 SHALL have parameter TimeoutCycles, default 1_000_000: watchdog limit while in test (>=2).
REQ-005 SHALL have port clk_i, input, 1 bit: the only clock.
REQ-006 SHALL have port rst_ni, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port req_valid_i, input, NumReq bits: per-requester write request.
REQ-008 SHALL have port req_addr_i, input, NumReq x AddrWidth bits: per-requester address.
REQ-009 SHALL have port req_data_i, input, NumReq x 16 bits: per-requester data.
REQ-010 SHALL have port req_ready_o, output, NumReq bits: one-hot grant; the write is accepted when valid and ready are both high.
REQ-011 SHALL have port wr_valid_o, output, 1 bit: qualified write to the status monitor.
REQ-012 SHALL have port wr_addr_o, output, AddrWidth bits: forwarded address.
REQ-013 SHALL have port wr_data_o, output, 16 bits: forwarded data.
REQ-014 SHALL have port test_state_o, output, 3 bits: current test_state_e.
REQ-015 SHALL have port test_done_o, output, 1 bit: state is Passed, Failed or Timeout.
REQ-016 SHALL have port test_passed_o, output, 1 bit: state is Passed.

Function
REQ-017 SHALL grant at most one requester per cycle, combinationally, using round-robin priority starting at pointer rr_q.
REQ-018 SHALL move rr_q to (granted index + 1) mod NumReq on each accepted write, and SHALL hold rr_q when no write is accepted.
REQ-019 SHALL register the accepted write so that wr_valid_o, wr_addr_o and wr_data_o appear exactly 1 cycle after acceptance; wr_valid_o SHALL be low otherwise and addr/data SHALL then hold their last values.
REQ-020 SHALL sustain one write per cycle; there is no backpressure from the monitor side.
REQ-021 SHALL decode the state only from a registered write whose wr_addr_o equals StatusAddr; writes to any other address SHALL be forwarded with no effect on the state.
REQ-022 SHALL implement FSM states Idle(0), BootRom(1), InTest(2), Passed(3), Failed(4), Timeout(5).
REQ-023 SHALL, from a non-terminal state: on code 16'hB004 go to BootRom; on 16'h4354 go to InTest; on 16'h900D go to Passed; on 16'hBAAD go to Failed; on any other code hold the current state.
REQ-024 SHALL treat Passed, Failed and Timeout as sticky until reset; later status writes are still forwarded but SHALL NOT change the state.
REQ-025 SHALL run a watchdog counter of width $clog2(TimeoutCycles+1) that increments each cycle while in InTest and clears on entering InTest or on any recognised code write.
REQ-026 SHALL enter Timeout when the counter equals TimeoutCycles-1 in InTest with no recognised code write that cycle; a code write in the same cycle SHALL take priority.
REQ-027 SHALL NOT let the counter wrap; it is frozen outside InTest.
REQ-028 SHALL drive test_state_o, test_done_o and test_passed_o directly from registers.

Reset
REQ-029 SHALL, on rst_ni low (any time, including mid-transfer), drive immediately: rr_q=0, wr_valid_o=0, wr_addr_o=0, wr_data_o=0, state=Idle, counter=0, test_done_o=0, test_passed_o=0.
REQ-030 SHALL drop a write that is pending in the output register when reset asserts.

Structure
REQ-031 SHALL place test_state_e, the four status-code constants and the default StatusAddr in package sw_test_status_pkg.
REQ-032 SHALL implement round-robin selection in one sub-module, sw_test_status_rr_arb (request, pointer -> one-hot grant, index); FSM and watchdog stay in the top module.

Verification
REQ-033 Bench SHALL check: req_valid_i=4'b1111 held for 4 cycles with rr_q=0 -> grants 0,1,2,3 in order, and wr_valid_o high on cycles 2..5.
REQ-034 Bench SHALL check: requester 2 writes 16'hB004 then 16'h4354 to StatusAddr -> test_state_o goes 1 then 2, each change 2 cycles after its acceptance.
REQ-035 Bench SHALL check: TimeoutCycles=16, enter InTest, then no writes -> test_state_o=5 and test_done_o=1 after 16 cycles, test_passed_o=0.
REQ-036 Bench SHALL check: TimeoutCycles=16, 16'h900D lands on the same cycle the counter hits 15 -> state Passed, not Timeout; a later 16'hBAAD leaves the state Passed.
REQ-037 Bench SHALL check: write 16'h900D to StatusAddr+4 -> it is forwarded on wr_* and the state is unchanged.
REQ-038 Bench SHALL check: rst_ni pulsed low while wr_valid_o=1 in InTest -> all outputs zero at once, and the next grant goes to requester 0.
